// File: rtl/inst_align_queue.sv
// Parcel queue between ifetch and decode: splits 32-bit fetch words into 16-bit parcels
// and presents one aligned instruction per cycle. Define RVC_EN to enable compressed parcels.
module inst_align_queue #(
    parameter int QUEUE_BIT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    input  logic [31:0]          fetch_data,
    output logic                 fetch_ready,
    output logic                 out_valid,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc,
    output logic                 out_is_c,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [QUEUE_BIT:0]   occupancy
);

    localparam int DEPTH = 2 ** QUEUE_BIT;
    localparam logic [QUEUE_BIT-1:0] PTR_ONE  = 1;
    localparam logic [QUEUE_BIT:0]   CNT_ONE  = 1;
    localparam logic [QUEUE_BIT:0]   CNT_TWO  = 2;
    localparam logic [QUEUE_BIT:0]   CNT_ENQ  = QUEUE_BIT'(0) + (DEPTH - 2);

    logic [15:0]          r_parcel [DEPTH];
    logic [30:0]          r_ppc    [DEPTH];
    logic [QUEUE_BIT-1:0] r_head, r_tail;
    logic [QUEUE_BIT:0]   r_count;

    logic [QUEUE_BIT-1:0] w_head1, w_tail1;
    logic [15:0]          w_p0, w_p1;
    logic                 w_is_c, w_valid, w_half, w_enq, w_deq;
    logic [QUEUE_BIT:0]   w_enq_n, w_deq_n;

`ifdef RVC_EN
    logic w_unused_pc;
    assign w_unused_pc = fetch_pc[0];
    assign w_is_c = (w_p0[1:0] != 2'b11);
    assign w_half = fetch_pc[1];
`else
    logic w_unused_pc;
    assign w_unused_pc = ^fetch_pc[1:0];
    assign w_is_c = 1'b0;
    assign w_half = 1'b0;
`endif

    assign w_head1 = r_head + PTR_ONE;
    assign w_tail1 = r_tail + PTR_ONE;
    assign w_p0    = r_parcel[r_head];
    assign w_p1    = r_parcel[w_head1];

    // A 32-bit instruction waits at head until its upper parcel has been queued.
    assign w_valid = (r_count >= CNT_ONE) && (w_is_c || (r_count >= CNT_TWO));

    // Conservative: a same-cycle dequeue does not free room for this fetch.
    assign fetch_ready = (r_count <= CNT_ENQ);

    assign w_enq = fetch_valid && fetch_ready && !flush && rdy_in;
    assign w_deq = w_valid && out_ready && !flush && rdy_in;

    assign w_enq_n = !w_enq ? '0 : (w_half ? CNT_ONE : CNT_TWO);
    assign w_deq_n = !w_deq ? '0 : (w_is_c ? CNT_ONE : CNT_TWO);

    assign out_valid = w_valid;
    assign out_is_c  = w_valid && w_is_c;
    assign out_inst  = !w_valid ? 32'h0 : (w_is_c ? {16'h0, w_p0} : {w_p1, w_p0});
    assign out_pc    = !w_valid ? 32'h0 : {r_ppc[r_head], 1'b0};
    assign occupancy = r_count;

    // Storage needs no reset: head decode is masked by count.
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            if (w_half) begin
                r_parcel[r_tail] <= fetch_data[31:16];
                r_ppc[r_tail]    <= fetch_pc[31:1];
            end else begin
                r_parcel[r_tail]  <= fetch_data[15:0];
                r_ppc[r_tail]     <= {fetch_pc[31:2], 1'b0};
                r_parcel[w_tail1] <= fetch_data[31:16];
                r_ppc[w_tail1]    <= {fetch_pc[31:2], 1'b1};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + w_deq_n[QUEUE_BIT-1:0];
                r_tail  <= r_tail + w_enq_n[QUEUE_BIT-1:0];
                r_count <= r_count + w_enq_n - w_deq_n;
            end
        end
    end

endmodule

// File: tb/tb_inst_align_queue.sv
// Directed bench for inst_align_queue: a parcel-queue model checked every cycle,
// plus literal expectations for both RVC_EN builds.
module tb_inst_align_queue;

    localparam int QB    = 4;
    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, fetch_valid, out_ready, flush;
    logic [31:0] fetch_pc, fetch_data;
    logic        fetch_ready, out_valid, out_is_c;
    logic [31:0] out_inst, out_pc;
    logic [QB:0] occupancy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] d;
        logic [31:0] pc;
    } parcel_t;
    parcel_t mq[$];

    inst_align_queue #(.QUEUE_BIT(QB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
        .fetch_ready(fetch_ready), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_is_c(out_is_c), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_is_c();
`ifdef RVC_EN
        return (mq.size() > 0) && (mq[0].d[1:0] != 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        return (mq.size() >= 1) && (m_is_c() || mq.size() >= 2);
    endfunction

    // Model: a plain queue of parcels, updated on each accepted clock edge.
    always @(posedge clk_in or posedge rst_in) begin : model
        bit ok_enq, ok_deq;
        int nd;
        parcel_t p;
        if (rst_in) mq.delete();
        else if (rdy_in) begin
            if (flush) mq.delete();
            else begin
                ok_enq = fetch_valid && (DEPTH - mq.size() >= 2);
                ok_deq = m_valid() && out_ready;
                nd     = m_is_c() ? 1 : 2;
                if (ok_deq) repeat (nd) void'(mq.pop_front());
                if (ok_enq) begin
`ifdef RVC_EN
                    if (fetch_pc[1]) begin
                        p.d = fetch_data[31:16]; p.pc = fetch_pc; mq.push_back(p);
                    end else begin
                        p.d = fetch_data[15:0];  p.pc = fetch_pc;         mq.push_back(p);
                        p.d = fetch_data[31:16]; p.pc = fetch_pc + 32'd2; mq.push_back(p);
                    end
`else
                    p.d = fetch_data[15:0];  p.pc = {fetch_pc[31:2], 2'b00}; mq.push_back(p);
                    p.d = fetch_data[31:16]; p.pc = {fetch_pc[31:2], 2'b10}; mq.push_back(p);
`endif
                end
            end
        end
    end

    always @(negedge clk_in) begin : compare
        logic [31:0] e_inst, e_pc;
        bit e_v, e_c;
        e_v = m_valid();
        e_c = e_v && m_is_c();
        e_inst = 32'h0;
        e_pc   = 32'h0;
        if (e_v) begin
            e_pc = mq[0].pc;
            if (e_c) e_inst = {16'h0, mq[0].d};
            else     e_inst = {mq[1].d, mq[0].d};
        end
        chk("occupancy",   32'(occupancy),   32'(mq.size()));
        chk("fetch_ready", 32'(fetch_ready), 32'(DEPTH - mq.size() >= 2));
        chk("out_valid",   32'(out_valid),   32'(e_v));
        chk("out_is_c",    32'(out_is_c),    32'(e_c));
        chk("out_inst",    out_inst,         e_inst);
        chk("out_pc",      out_pc,           e_pc);
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        fetch_pc    = pc;
        fetch_data  = data;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic head(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                        input logic c, input int occ);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_inst"},  out_inst, inst);
        chk({nm, "_pc"},    out_pc, pc);
        chk({nm, "_is_c"},  32'(out_is_c), 32'(c));
        chk({nm, "_occ"},   32'(occupancy), 32'(occ));
    endtask

    task automatic empty_chk(input string nm);
        chk({nm, "_occ"},   32'(occupancy), 32'd0);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_fr"},    32'(fetch_ready), 32'd1);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; fetch_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        fetch_pc = 32'h0; fetch_data = 32'h0;
        #1 rst_in = 1'b1;
        tick(); tick();
        empty_chk("reset");
        chk("reset_inst", out_inst, 32'h0);
        chk("reset_pc",   out_pc,   32'h0);
        rst_in = 1'b0;
        tick();

        // single 32-bit word
        fetch(32'h0, 32'h00a00513);
        head("t1", 32'h00a00513, 32'h0, 1'b0, 2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        empty_chk("t1_drain");

        // two compressed parcels in one word
        out_ready = 1'b1;
        fetch(32'h10, 32'h45050505);
`ifdef RVC_EN
        head("t2a", 32'h00000505, 32'h10, 1'b1, 2);
        tick();
        head("t2b", 32'h00004505, 32'h12, 1'b1, 1);
`else
        head("t2", 32'h45050505, 32'h10, 1'b0, 2);
        tick();
`endif
        tick();
        empty_chk("t2_drain");

        // 32-bit instruction straddling two fetch words
        fetch(32'h20, 32'h05130505);
`ifdef RVC_EN
        head("t3a", 32'h00000505, 32'h20, 1'b1, 2);
        tick();
        chk("t3_wait_valid", 32'(out_valid), 32'd0);
        chk("t3_wait_occ",   32'(occupancy), 32'd1);
`else
        head("t3a", 32'h05130505, 32'h20, 1'b0, 2);
        tick();
`endif
        fetch(32'h24, 32'h000100a0);
`ifdef RVC_EN
        head("t3b", 32'h00a00513, 32'h22, 1'b0, 3);
        tick();
        head("t3c", 32'h00000001, 32'h26, 1'b1, 1);
`else
        head("t3b", 32'h000100a0, 32'h24, 1'b0, 2);
        tick();
`endif
        tick();
        empty_chk("t3_drain");
        out_ready = 1'b0;

        // fetch starting at the upper halfword
        fetch(32'h32, 32'h45050505);
`ifdef RVC_EN
        head("t4", 32'h00004505, 32'h32, 1'b1, 1);
`else
        head("t4", 32'h45050505, 32'h30, 1'b0, 2);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        empty_chk("t4_drain");

        // fill to full, then an ignored ninth word
        for (int i = 0; i < 8; i++) fetch(32'h100 + 32'(4 * i), 32'h13 | (32'(i) << 7));
        fetch(32'h120, 32'h00000093);
        chk("t5_full_occ", 32'(occupancy), 32'd16);
        chk("t5_full_fr",  32'(fetch_ready), 32'd0);
        head("t5_head", 32'h00000013, 32'h100, 1'b0, 16);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t5_deq_occ", 32'(occupancy), 32'd14);
        chk("t5_deq_fr",  32'(fetch_ready), 32'd1);
        head("t5_next", 32'h00000093, 32'h104, 1'b0, 14);
        out_ready = 1'b1; repeat (7) tick(); out_ready = 1'b0;
        empty_chk("t5_drain");

        // flush beats same-cycle fetch and dequeue
        fetch(32'h40, 32'h00a00513);
        fetch_valid = 1'b1; fetch_pc = 32'h44; fetch_data = 32'h00b00593;
        out_ready = 1'b1; flush = 1'b1;
        tick();
        fetch_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        empty_chk("t6_flush");

        // rdy_in low freezes everything, including flush
        fetch(32'h50, 32'h00a00513);
        rdy_in = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h54; out_ready = 1'b1; flush = 1'b1;
        tick(); tick();
        head("t6_frozen", 32'h00a00513, 32'h50, 1'b0, 2);
        rdy_in = 1'b1; fetch_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        // asynchronous reset mid-stream
        rst_in = 1'b1;
        #1;
        empty_chk("t6_rst");
        tick();
        rst_in = 1'b0;
        tick();

        // mixed stream with backpressure; pointers wrap repeatedly
        for (int i = 0; i < 48; i++) begin
            fetch_valid = (i % 3 != 0);
            fetch_pc    = 32'h200 + 32'(4 * i) + ((i % 4 == 1) ? 32'd2 : 32'd0);
            fetch_data  = {16'h4505 ^ 16'(i), (i % 2 == 1) ? 16'h0505 : 16'h0513};
            out_ready   = (i % 5 != 2);
            tick();
        end
        fetch_valid = 1'b0;
        out_ready   = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
